// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program-memory writer for the SMP8 core. It takes instruction bytes from the
// host over a valid/ready handshake and stores them in a DEPTH x WIDTH
// instruction memory. It serves `instr` combinationally at the datapath's `pc`,
// and it holds the core in reset while a program is being loaded.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   reset      in   asynchronous, active-high; clears all state including memory
//   in_valid   in   host presents a byte on in_data
//   in_data    in   instruction byte
//   in_last    in   final byte of the program (looked at only on acceptance)
//   in_ready   out  loader can accept a byte this cycle
//   reload     in   single-cycle request to restart loading
//   pc         in   datapath program counter
//   instr      out  instruction at pc while running, 0 while loading
//   cpu_reset  out  hold the core in reset (high whenever not running)
//   count      out  bytes accepted in the current or most recent load
//   checksum   out  sum of accepted bytes mod 2^WIDTH for that load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic                     reload,
  input  logic [$clog2(DEPTH)-1:0] pc,
  output logic [WIDTH-1:0]         instr,
  output logic                     cpu_reset,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              accept;

  // reload takes priority over a byte offered in the same cycle.
  assign in_ready  = (state_q == LOAD) && !reload;
  assign accept    = in_valid && in_ready;
  assign cpu_reset = (state_q != RUN);
  assign instr     = (state_q == RUN) ? mem[pc] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // NOTE: next_state gets a default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = LOAD;
    end else if (accept && (in_last || wr_addr == LAST_ADDR)) begin
      // The final word always ends the load, even without in_last.
      state_d = RUN;
    end
  end

  // Write pointer and load statistics. A reload restarts them without
  // touching memory, so words past the new program's end survive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr  <= '0;
      count    <= '0;
      checksum <= '0;
    end else if (reload) begin
      wr_addr  <= '0;
      count    <= '0;
      checksum <= '0;
    end else if (accept) begin
      wr_addr  <= wr_addr + 1'b1;
      count    <= count + 1'b1;
      checksum <= checksum + in_data;
    end
  end

  // NOTE: the memory is built from resettable flops rather than a RAM macro,
  // because an async reset must discard a partially loaded program at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept) begin
      mem[wr_addr] <= in_data;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. The stimulus thread pushes a hand-computed
// snapshot of expected outputs into a queue whenever it wants them observed.
// A separate monitor pops each entry and compares it with the live DUT
// outputs at that instant.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       reload;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       cpu_reset;
  logic [4:0] count;
  logic [7:0] checksum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       ready;
    logic       cpu_rst;
    logic [7:0] instr;
    logic [4:0] count;
    logic [7:0] checksum;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(16), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .reload    (reload),
    .pc        (pc),
    .instr     (instr),
    .cpu_reset (cpu_reset),
    .count     (count),
    .checksum  (checksum)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares each queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      wait (exp_q.size() != 0);
      e = exp_q.pop_front();
      check({e.tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, e.ready});
      check({e.tag, ".cpu_reset"}, {7'd0, cpu_reset}, {7'd0, e.cpu_rst});
      check({e.tag, ".instr"},     instr,             e.instr);
      check({e.tag, ".count"},     {3'd0, count},     {3'd0, e.count});
      check({e.tag, ".checksum"},  checksum,          e.checksum);
    end
  end

  // Let combinational outputs settle, queue the expectation, then hold the
  // inputs steady while the monitor samples.
  task automatic snap(input string tag, input logic rdy, input logic crst,
                      input logic [7:0] ins, input logic [4:0] cnt,
                      input logic [7:0] cks);
    exp_t e;
    #1;
    e.tag = tag; e.ready = rdy; e.cpu_rst = crst;
    e.instr = ins; e.count = cnt; e.checksum = cks;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    reload = 1'b0; pc = 4'd0;
    #3;
    snap("reset", 1'b1, 1'b1, 8'h00, 5'd0, 8'h00);
    tick();
    reset = 1'b0;
    snap("after_reset", 1'b1, 1'b1, 8'h00, 5'd0, 8'h00);

    // Full load 0x10..0x1F with in_last never set; the 16th byte ends it.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) snap("full_15", 1'b1, 1'b1, 8'h00, 5'd15, 8'h59);
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    pc = 4'd5;
    snap("full_pc5", 1'b0, 1'b0, 8'h15, 5'd16, 8'h78);
    pc = 4'd15;
    snap("full_pc15", 1'b0, 1'b0, 8'h1F, 5'd16, 8'h78);

    // Bytes offered in RUN are ignored.
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (4) tick();
    in_valid = 1'b0;
    pc = 4'd3;
    snap("stall_pc3", 1'b0, 1'b0, 8'h13, 5'd16, 8'h78);

    // Short load after reload; in_ready drops during the reload cycle.
    reload = 1'b1;
    snap("reload_cycle", 1'b0, 1'b0, 8'h13, 5'd16, 8'h78);
    tick();
    reload = 1'b0;
    snap("reload_after", 1'b1, 1'b1, 8'h00, 5'd0, 8'h00);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b1);
    pc = 4'd2;
    snap("short_pc2", 1'b0, 1'b0, 8'hA3, 5'd3, 8'hE6);
    pc = 4'd4;
    snap("short_pc4", 1'b0, 1'b0, 8'h14, 5'd3, 8'hE6);
    pc = 4'd0;
    snap("short_pc0", 1'b0, 1'b0, 8'hA1, 5'd3, 8'hE6);

    // Reload colliding with an offered byte: no write, stats restart.
    pulse_reload();
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    snap("coll_pre", 1'b1, 1'b1, 8'h00, 5'd2, 8'h63);
    reload = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    snap("coll_cycle", 1'b0, 1'b1, 8'h00, 5'd2, 8'h63);
    tick();
    reload = 1'b0; in_valid = 1'b0;
    snap("coll_after", 1'b1, 1'b1, 8'h00, 5'd0, 8'h00);
    send_byte(8'h77, 1'b1);
    pc = 4'd0;
    snap("coll_pc0", 1'b0, 1'b0, 8'h77, 5'd1, 8'h77);
    pc = 4'd1;
    snap("coll_pc1", 1'b0, 1'b0, 8'h32, 5'd1, 8'h77);
    pc = 4'd2;
    snap("coll_pc2", 1'b0, 1'b0, 8'hA3, 5'd1, 8'h77);

    // Async reset between edges in the middle of a load.
    pulse_reload();
    for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b0);
    snap("mid_load", 1'b1, 1'b1, 8'h00, 5'd7, 8'h1C);
    #1 reset = 1'b1;
    snap("async_reset", 1'b1, 1'b1, 8'h00, 5'd0, 8'h00);
    reset = 1'b0;
    send_byte(8'h99, 1'b1);
    pc = 4'd0;
    snap("post_rst_pc0", 1'b0, 1'b0, 8'h99, 5'd1, 8'h99);
    pc = 4'd1;
    snap("post_rst_pc1", 1'b0, 1'b0, 8'h00, 5'd1, 8'h99);
    pc = 4'd15;
    snap("post_rst_pc15", 1'b0, 1'b0, 8'h00, 5'd1, 8'h99);

    // Every queued expectation must have been consumed by the monitor.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) #1;
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-memory writer for the SMP8 core: accepts a stream of instruction bytes over a valid/ready handshake, stores them in a 16 x 8 instruction memory, and serves `instr` combinationally at the datapath's 4-bit `pc`. It holds the core in reset while a program is being loaded and releases it when loading completes. It sits between the host/boot interface and the datapath's `instr`/`pc` pins.

## Interface
Parameters:
- `DEPTH`, 16: number of instruction words; fixed to match the 4-bit `pc`.
- `WIDTH`, 8: instruction width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_valid`  in  1  host presents a byte on `in_data`.
- `in_data`  in  8  instruction byte.
- `in_last`  in  1  qualifies `in_data` as the final byte of the program; sampled only on an accepted transfer.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle request to restart loading.
- `pc`  in  4  datapath program counter.
- `instr`  out  8  instruction at `pc`.
- `cpu_reset`  out  1  hold the core in reset; drives the datapath `reset`.
- `count`  out  5  number of bytes accepted in the current or most recent load (0..16).
- `checksum`  out  8  sum of accepted bytes mod 256 for the current or most recent load.

## Operation
- Two states, LOAD and RUN. Async reset enters LOAD, sets `wr_addr` = 0, `count` = 0, `checksum` = 0x00, and clears all 16 memory words to 0x00.
- `in_ready` = (state == LOAD) && !`reload`. This is combinational.
- A transfer is accepted on a rising edge with `in_valid` && `in_ready`. On each accepted transfer:
  - `mem[wr_addr]` <= `in_data`.
  - `wr_addr` <= `wr_addr` + 1 (4-bit, wraps to 0).
  - `count` <= `count` + 1.
  - `checksum` <= (`checksum` + `in_data`) mod 256.
- LOAD -> RUN on an accepted transfer when `in_last` = 1 or `wr_addr` = 15. The 16th byte always ends the load, regardless of `in_last`.
- Words not written during a short load keep their previous contents.
- RUN -> LOAD on a rising edge with `reload` = 1. That edge sets `wr_addr` = 0, `count` = 0 and `checksum` = 0; the memory is not cleared.
- `reload` in LOAD restarts the load with the same effects. Any bytes already written stay in memory until overwritten.
- `reload` has priority over a same-cycle byte: `in_ready` is low that cycle, so no transfer occurs.
- `cpu_reset` = (state != RUN). It is decoded directly from the state register, so it is glitch-free.
- `instr` = (state == RUN) ? `mem[pc]` : 0x00. The read is combinational and has no latency.
- `in_valid` while `in_ready` is low has no effect. The host must hold `in_data`/`in_last` until the byte is accepted.

## Timing
- Reset values: `in_ready` = 1, `cpu_reset` = 1, `instr` = 0x00, `count` = 0, `checksum` = 0x00.
- Throughput: one byte per cycle in LOAD, with back-to-back transfers allowed.
- Final byte accepted at edge N: `cpu_reset` and `in_ready` go low after edge N. The core's first `pc` = 0 fetch is therefore valid in the cycle following edge N.
- `reload` sampled at edge N: `cpu_reset` rises and `instr` returns to 0x00 after edge N. `in_ready` also goes low combinationally during the `reload` cycle itself.
- `instr` follows `pc` within the same cycle.
- The memory write at edge N is visible to reads after edge N.
- Async reset mid-load or mid-run: all outputs go to their reset values immediately, without waiting for `clk`. The partially loaded program is discarded.

## Test plan
- Reset: assert `reset` -> `in_ready` = 1, `cpu_reset` = 1, `instr` = 0x00, `count` = 0, `checksum` = 0x00.
- Full load: send 0x10..0x1F back-to-back with `in_last` = 0 -> after the 16th edge, `cpu_reset` = 0, `in_ready` = 0, `count` = 16, `checksum` = 0x78. Then `pc` = 5 -> `instr` = 0x15, and `pc` = 15 -> `instr` = 0x1F.
- Stall/ignore: in RUN, hold `in_valid` = 1 with `in_data` = 0xEE for 4 cycles -> memory unchanged (`pc` = 3 -> 0x13), `count` stays 16.
- Short load: `reload`, then send 0xA1, 0xA2, 0xA3 with `in_last` set on 0xA3 -> RUN, `count` = 3, `checksum` = 0xE6. `pc` = 2 -> 0xA3, and `pc` = 4 -> 0x14 (retained).
- Reload collision: in LOAD after 2 bytes, assert `reload` with `in_valid` = 1 and `in_data` = 0x55 -> `in_ready` = 0 that cycle, no write, `count` = 0 next cycle. The next byte accepted goes to address 0.
- Async reset mid-load: after 7 accepted bytes, pulse `reset` between clock edges -> immediately `count` = 0, `cpu_reset` = 1. After reload-free completion of a 1-byte load with `in_last`, `pc` = 1 -> 0x00 (memory cleared).
